// File: rtl/keypad_scanner.sv
// Row/column keypad scanner: one-hot-low row drive, 2-flop column synchronizer, press/release debounce.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat pulses while a key is held.
package calc_pkg;
  typedef struct packed {
    logic clear, mem_recall, mem_clear, mem_sub, mem_add, op_percent, op_sqrt;
    logic op_div, op_mul, op_sub, op_add, op_eq, dot;
    logic num_9, num_8, num_7, num_6, num_5, num_4, num_3, num_2, num_1, num_0;
  } buttons_t;
endpackage

module keypad_scanner #(
  parameter int unsigned NumRows        = 5,
  parameter int unsigned NumCols        = 5,
  parameter int unsigned SettleCycles   = 3,
  parameter int unsigned DebounceCycles = 8,
  parameter int unsigned RepeatDelay    = 500,
  parameter int unsigned RepeatPeriod   = 100
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumCols-1:0]                   cols_ni,
  output logic [NumRows-1:0]                   rows_no,
  output calc_pkg::buttons_t                   buttons_o,
  output logic                                 key_valid_o,
  output logic [$clog2(NumRows*NumCols)-1:0]   key_code_o
);

  localparam int unsigned RowW      = $clog2(NumRows);
  localparam int unsigned ColW      = $clog2(NumCols);
  localparam int unsigned CntW      = ColW + 1;
  localparam int unsigned KeyW      = $clog2(NumRows*NumCols);
  localparam int unsigned SetW      = $clog2(SettleCycles);
  localparam int unsigned DebW      = $clog2(DebounceCycles);
  localparam int unsigned NumFields = $bits(calc_pkg::buttons_t);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

  state_e             state_q, state_d;
  logic [RowW-1:0]    row_q, row_d, row_next;
  logic [SetW-1:0]    settle_q, settle_d;
  logic [ColW-1:0]    col_q, col_d, act_col;
  logic [DebW-1:0]    cnt_q, cnt_d;
  logic [NumCols-1:0] sync1_q, sync2_q, act, cand_mask;
  logic [CntW-1:0]    n_act;
  calc_pkg::buttons_t buttons_q, buttons_d;
  logic               valid_q, valid_d;
  logic [KeyW-1:0]    code_q, code_d;
  logic [31:0]        code_full;
  logic [NumFields-1:0] field_onehot;

  assign rows_no     = ~(NumRows'(1) << row_q);
  assign buttons_o   = buttons_q;
  assign key_valid_o = valid_q;
  assign key_code_o  = code_q;

  assign act       = ~sync2_q;
  assign cand_mask = NumCols'(1) << col_q;
  assign row_next  = (row_q == RowW'(NumRows-1)) ? '0 : row_q + RowW'(1);
  assign code_full = 32'(row_q) * NumCols + 32'(col_q);
  assign field_onehot = (code_full < NumFields) ? (NumFields'(1) << code_full) : '0;

  always_comb begin
    n_act   = '0;
    act_col = '0;
    for (int unsigned i = 0; i < NumCols; i++) begin
      if (act[i]) begin
        n_act   = n_act + CntW'(1);
        act_col = ColW'(i);
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepMax = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  logic [RepW-1:0] rep_q, rep_d, rep_last;
  logic            rep_first_q, rep_first_d;

  assign rep_last = rep_first_q ? RepW'(RepeatDelay - 1) : RepW'(RepeatPeriod - 1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(RepeatDelay), 32'(RepeatPeriod)};
`endif

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    settle_d  = settle_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    code_d    = code_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (settle_q == SetW'(SettleCycles - 1)) begin
          settle_d = '0;
          if (n_act == CntW'(1)) begin
            col_d   = act_col;
            cnt_d   = DebW'(1);
            state_d = DEBOUNCE;
          end else begin
            row_d = row_next;
          end
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end
      DEBOUNCE: begin
        if (act != cand_mask) begin
          state_d  = SCAN;
          row_d    = row_next;
          settle_d = '0;
        end else if (cnt_q == DebW'(DebounceCycles - 1)) begin
          state_d   = HELD;
          cnt_d     = '0;
          valid_d   = 1'b1;
          code_d    = code_full[KeyW-1:0];
          buttons_d = field_onehot;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d       = '0;
          rep_first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + DebW'(1);
        end
      end
      HELD: begin
        // Only the held column matters; a completed release wins over a repeat in the same cycle.
        cnt_d = act[col_q] ? '0 : cnt_q + DebW'(1);
        if (!act[col_q] && cnt_q == DebW'(DebounceCycles - 1)) begin
          state_d   = SCAN;
          row_d     = row_next;
          settle_d  = '0;
          cnt_d     = '0;
          buttons_d = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rep_q == rep_last) begin
          valid_d     = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_d = rep_q + RepW'(1);
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= SCAN;
      row_q     <= '0;
      settle_q  <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      sync1_q   <= '1;
      sync2_q   <= '1;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      settle_q  <= settle_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      sync1_q   <= cols_ni;
      sync2_q   <= sync1_q;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a key-matrix model drives columns from rows_no;
// expected pulses are queued by the stimulus and checked by an independent monitor.
module tb_keypad_scanner;
  localparam int unsigned NR = 5;
  localparam int unsigned NC = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NC-1:0]      cols_n;
  logic [NR-1:0]      rows_n;
  calc_pkg::buttons_t buttons;
  logic               key_valid;
  logic [4:0]         key_code;
  logic [NR*NC-1:0]   pressed;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [4:0]  code;
    logic [22:0] btn;
  } exp_t;
  exp_t exp_q[$];
  int   pulse_cyc[$];

  keypad_scanner #(
    .NumRows(NR), .NumCols(NC), .SettleCycles(3), .DebounceCycles(8),
    .RepeatDelay(20), .RepeatPeriod(5)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .cols_ni(cols_n), .rows_no(rows_n),
    .buttons_o(buttons), .key_valid_o(key_valid), .key_code_o(key_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Switch matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    cols_n = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (pressed[r*NC+c] && !rows_n[r]) cols_n[c] = 1'b0;
  end

  function automatic logic [22:0] fld(input int idx);
    logic [22:0] one;
    one = 23'd1;
    return (idx < 23) ? (one << idx) : 23'd0;
  endfunction

  function automatic logic [NR-1:0] row_pat(input int r);
    logic [NR-1:0] one;
    one = NR'(1);
    return ~(one << r);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic expect_key(input int idx);
    exp_t e;
    e.code = 5'(idx);
    e.btn  = fld(idx);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      exp_t e;
      pulse_cyc.push_back(cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got code %0d buttons 0x%0h expected no pulse", key_code, buttons);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e.code || buttons !== e.btn) begin
          miscompares++;
          $display("FAIL pulse: got code %0d buttons 0x%0h expected code %0d buttons 0x%0h",
                   key_code, buttons, e.code, e.btn);
        end
      end
    end
  end

  initial begin
    int press_cyc;
    int n_exp;
    int offs[6];
    offs = '{0, 20, 25, 30, 35, 40};
    pressed = '0;
    rst_n   = 1'b0;
    step(3);
    rst_n = 1'b1;

    check("rst_rows", rows_n, 5'b11110);
    check("rst_buttons", {9'd0, buttons}, 0);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);

    for (int k = 0; k < 16; k++) begin
      check("row_walk", rows_n, row_pat((k / 3) % 5));
      step(1);
    end

    // Key (2,1) -> 11 / op_eq; release takes 2 sync + 8 debounce cycles.
    pressed[11] = 1'b1;
    expect_key(11);
    wait_drain("op_eq", 200);
    step(3);
    check("op_eq_level", {9'd0, buttons}, {9'd0, fld(11)});
    pressed[11] = 1'b0;
    step(9);
    check("op_eq_still_held", {9'd0, buttons}, {9'd0, fld(11)});
    step(1);
    check("op_eq_released", {9'd0, buttons}, 0);
    check("resume_row3", rows_n, 5'b10111);
    check("code_holds", key_code, 11);

    // Press (3,4) while row3 just started: sample 2 cycles later, pulse 8 after that.
    pressed[19] = 1'b1;
    press_cyc = cyc;
    pulse_cyc.delete();
    expect_key(19);
    wait_drain("latency", 100);
    check("latency", (pulse_cyc.size() > 0) ? pulse_cyc[0] - press_cyc : -1, 10);
    pressed[19] = 1'b0;
    step(14);

    for (int k = 0; k < 60; k++) begin
      pressed[3] = ((k % 5) < 3);
      step(1);
    end
    pressed[3] = 1'b1;
    expect_key(3);
    wait_drain("bounce", 200);
    check("bounce_level", {9'd0, buttons}, {9'd0, fld(3)});
    pressed[3] = 1'b0;
    step(14);

    pressed[0] = 1'b1;
    pressed[2] = 1'b1;
    step(40);
    check("ghost_code", key_code, 3);
    pressed[0] = 1'b0;
    expect_key(2);
    wait_drain("single_col2", 200);
    pressed[2] = 1'b0;
    step(14);

    // Unmapped (4,4); release exits to row0 at a known cycle, used to align the reset abort.
    pressed[24] = 1'b1;
    expect_key(24);
    wait_drain("unmapped", 200);
    step(3);
    check("unmapped_level", {9'd0, buttons}, 0);
    check("unmapped_code", key_code, 24);
    pressed[24] = 1'b0;
    step(10);
    check("wrap_row0", rows_n, 5'b11110);
    pressed[7] = 1'b1;
    step(8);
    rst_n = 1'b0;
    step(1);
    check("abort_rows", rows_n, 5'b11110);
    check("abort_buttons", {9'd0, buttons}, 0);
    check("abort_valid", key_valid, 0);
    check("abort_code", key_code, 0);
    pressed[7] = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(30);
    check("abort_code_after", key_code, 0);

`ifdef KEYPAD_AUTOREPEAT_EN
    n_exp = 6;
`else
    n_exp = 1;
`endif
    pulse_cyc.delete();
    pressed[5] = 1'b1;
    for (int i = 0; i < n_exp; i++) expect_key(5);
    for (int i = 0; i < 200 && pulse_cyc.size() == 0; i++) step(1);
    step(32);
    pressed[5] = 1'b0;
    step(20);
    wait_drain("repeat", 10);
    check("repeat_count", pulse_cyc.size(), n_exp);
    for (int i = 1; i < pulse_cyc.size() && i < n_exp; i++)
      check("repeat_time", pulse_cyc[i] - pulse_cyc[0], offs[i]);
    check("repeat_release", {9'd0, buttons}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a row/column push-button matrix on the board, synchronizes and debounces the column returns, and produces calc_pkg::buttons_t for the calculator core. Drop-in replacement for switch-derived buttons in the board tops. Runs in the calculator clock domain, which is the divided board clock. Input-side counterpart of the time-multiplexed 7-segment anode scan: rows are driven one at a time, and columns are read back.

Parameters:
NumRows, 5, number of matrix rows driven (≥2)
NumCols, 5, number of matrix columns read (≥2)
SettleCycles, 3, cycles a row is driven before its columns are sampled (≥3; covers the 2-flop synchronizer)
DebounceCycles, 8, consecutive matching samples needed to accept a press or a release (≥2)
RepeatDelay, 500, cycles held before the first auto-repeat (feature only)
RepeatPeriod, 100, cycles between later auto-repeats (feature only)

Ports:
clk_i  input  1  calculator clock
rst_ni  input  1  synchronous active-low reset
cols_ni  input  NumCols  raw column returns, active-low, external pull-ups, asynchronous
rows_no  output  NumRows  row drives, active-low, one-hot-low
buttons_o  output  calc_pkg::buttons_t  level: accepted key's field high while held
key_valid_o  output  1  one-cycle pulse per accepted press (and per repeat)
key_code_o  output  $clog2(NumRows*NumCols)  index of the last accepted key, = row*NumCols+col

Behaviour:
- Reset (rst_ni low at a clk_i edge): state=SCAN, row=0, settle counter=0, rows_no = all ones except bit0 = 0, buttons_o='0, key_valid_o=0, key_code_o=0, sync flops = all ones. Reset mid-press aborts; no pulse is emitted.
- Columns pass through a 2-flop synchronizer; "sample" always means the synchronized value, inverted to active-high.
- Key map, index → field: 0-9 num_0..num_9, 10 dot, 11 op_eq, 12 op_add, 13 op_sub, 14 op_mul, 15 op_div, 16 op_sqrt, 17 op_percent, 18 mem_add, 19 mem_sub, 20 mem_clear, 21 mem_recall, 22 clear. Indices ≥23 are unmapped: key_valid_o still pulses, buttons_o stays '0.
- SCAN:
  - Drive row r. The settle counter counts 0..SettleCycles-1; the sample is taken in the cycle where the counter = SettleCycles-1.
  - Zero columns active → r advances; wrap NumRows-1→0, counter=0.
  - Exactly one column c active → latch candidate (r,c), debounce count=1, go DEBOUNCE; row is held.
  - Two or more active (ghosting/multi-press) → treated as no key; r advances.
- DEBOUNCE: sample every cycle.
  - Sample == onehot(c) → count++.
  - Any mismatch → SCAN, row advances.
  - When count reaches DebounceCycles → next cycle: key_valid_o=1 for one cycle, key_code_o=r*NumCols+c, mapped field set in buttons_o, go HELD.
- HELD: row stays driven.
  - buttons_o is held.
  - Release count increments on each cycle where bit c is inactive and resets when it is active. Other columns are ignored (no rollover).
  - Release count reaches DebounceCycles → buttons_o='0 next cycle, go SCAN, row advances.
- key_code_o holds its value until the next accepted press.
- Latency: a press stable from the scan sample yields key_valid_o exactly DebounceCycles cycles after that sample cycle.
- Row scan period with no keys = NumRows*SettleCycles cycles.

Optional Feature:
KEYPAD_AUTOREPEAT_EN:
- Defined: in HELD a repeat counter runs. key_valid_o re-pulses, with the same key_code_o, RepeatDelay cycles after the initial pulse, then every RepeatPeriod cycles until release. buttons_o stays level throughout.
- The counter clears on entering HELD.
- Undefined: exactly one pulse per press; RepeatDelay and RepeatPeriod are unused; no repeat counter is synthesized.

Test Plan:
- Reset, no keys, NumRows=5, SettleCycles=3 → rows_no walks 11110,11101,11011,10111,01111, each driven 3 cycles, then wraps to 11110; key_valid_o never asserts.
- Key (row2,col1) held low, DebounceCycles=8 → exactly one key_valid_o pulse, key_code_o=11, buttons_o.op_eq=1 while held. After release plus 8 cycles, buttons_o='0 and scanning resumes at row3.
- Key (0,3) bounces with 3 active / 2 inactive samples, then holds → no pulse during the bounce; one pulse with key_code_o=3 (num_3) once 8 consecutive active samples occur.
- Row0 with cols 0 and 2 both active → no pulse, row advances; then only col2 active → pulse with key_code_o=2.
- Key (4,4) pressed → key_valid_o pulses, key_code_o=24, buttons_o stays '0. Assert rst_ni=0 mid-DEBOUNCE on another key → all outputs at reset values, no pulse.
- With KEYPAD_AUTOREPEAT_EN, RepeatDelay=20, RepeatPeriod=5, key held 40 cycles past the first pulse → pulses at +0, +20, +25, +30, +35, +40; without the macro → a single pulse.
